// File: rtl/dircc_debug_scan_slave_mc.sv
// Multi-channel virtual-JTAG debug scan slave: synchronised DR capture/shift/update feeding
// one command at a time to N_CH CPU debug channels. Define DIRCC_DEBUG_SLAVE_PARITY_EN for odd-parity checking on update.
module dircc_debug_scan_slave_mc #(
  parameter int unsigned DR_W = 38,
  parameter int unsigned IR_W = 2,
  parameter int unsigned N_CH = 2,
  parameter int unsigned CH_W = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             vji_tck,
  input  logic                             vji_tdi,
  input  logic                             vji_cdr,
  input  logic                             vji_sdr,
  input  logic                             vji_udr,
  input  logic                             vji_uir,
  input  logic [IR_W-1:0]                  vji_ir_in,
  output logic                             vji_tdo,
  output logic [N_CH-1:0]                  cmd_valid,
  input  logic [N_CH-1:0]                  cmd_ready,
  output logic [IR_W-1:0]                  cmd_ir,
  output logic [DR_W-CH_W-1:0]             cmd_data,
  input  logic [N_CH*(DR_W-CH_W)-1:0]      rd_data,
  output logic                             busy,
  output logic                             overrun,
  output logic                             parity_err
);

  localparam int unsigned P  = DR_W - CH_W;
  localparam int unsigned NS = 6 + IR_W;

  typedef enum logic {IDLE, PEND} state_t;

  logic [NS-1:0]   sync1, sync2;
  logic            tck_d, udr_d, uir_d;
  logic            tck_s, tdi_s, cdr_s, sdr_s, udr_s, uir_s;
  logic [IR_W-1:0] ir_s;
  logic            tck_rise, udr_rise, uir_rise, cap, shift;

  logic [DR_W-1:0] sr;
  logic [IR_W-1:0] ir_q;
  logic [CH_W-1:0] sel_q, sel_d, ch;
  logic [P-1:0]    rd_sel, data_d;
  logic [IR_W-1:0] cmdir_d;
  logic [N_CH-1:0] valid_d;
  logic            busy_d, ovr_d, hs, can, accept, ovr_set;
  state_t          state_q, state_d;

  // Two-flop synchronisers on every virtual-JTAG input, plus one edge-detect stage
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      tck_d <= 1'b0;
      udr_d <= 1'b0;
      uir_d <= 1'b0;
    end else begin
      sync1 <= {vji_ir_in, vji_uir, vji_udr, vji_sdr, vji_cdr, vji_tdi, vji_tck};
      sync2 <= sync1;
      tck_d <= tck_s;
      udr_d <= udr_s;
      uir_d <= uir_s;
    end
  end

  assign tck_s = sync2[0];
  assign tdi_s = sync2[1];
  assign cdr_s = sync2[2];
  assign sdr_s = sync2[3];
  assign udr_s = sync2[4];
  assign uir_s = sync2[5];
  assign ir_s  = sync2[NS-1 -: IR_W];

  assign tck_rise = tck_s & ~tck_d;
  assign udr_rise = udr_s & ~udr_d;
  assign uir_rise = uir_s & ~uir_d;
  assign cap      = tck_rise & cdr_s;
  assign shift    = tck_rise & sdr_s & ~cdr_s;
  assign ch       = sr[DR_W-1 -: CH_W];

  always_comb begin
    rd_sel = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (sel_q == CH_W'(c)) rd_sel = rd_data[c*P +: P];
    end
  end

  // Scan register, serial out and virtual IR
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      ir_q    <= '0;
      vji_tdo <= 1'b0;
    end else begin
      if (cap) begin
        sr <= {sel_q, rd_sel};
      end else if (shift) begin
        sr      <= {tdi_s, sr[DR_W-1:1]};
        vji_tdo <= sr[0];
      end
      if (uir_rise) ir_q <= ir_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

`ifdef DIRCC_DEBUG_SLAVE_PARITY_EN
  logic par_set, par_d;
`endif

  // Next state, command latch and sticky flags; a same-cycle set beats the capture clear
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = cmd_data;
    cmdir_d = cmd_ir;
    accept  = 1'b0;
    ovr_set = 1'b0;
`ifdef DIRCC_DEBUG_SLAVE_PARITY_EN
    par_set = 1'b0;
`endif
    hs  = (state_q == PEND) && ((cmd_ready & cmd_valid) != '0);
    can = (state_q == IDLE) || hs;
    if (hs) state_d = IDLE;
    if (udr_rise) begin
`ifdef DIRCC_DEBUG_SLAVE_PARITY_EN
      if (!(^sr)) par_set = 1'b1;
      else
`endif
      if (32'(ch) < N_CH) begin
        if (can) accept  = 1'b1;
        else     ovr_set = 1'b1;
      end
    end
    if (accept) begin
      state_d = PEND;
      sel_d   = ch;
      data_d  = sr[P-1:0];
      cmdir_d = ir_q;
    end
    valid_d = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      valid_d[c] = (state_d == PEND) && (sel_d == CH_W'(c));
    end
    busy_d = (state_d == PEND);
    ovr_d  = overrun;
    if (cap)     ovr_d = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
`ifdef DIRCC_DEBUG_SLAVE_PARITY_EN
    par_d = parity_err;
    if (cap)     par_d = 1'b0;
    if (par_set) par_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= '0;
      cmd_data  <= '0;
      cmd_ir    <= '0;
      cmd_valid <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      cmd_data  <= data_d;
      cmd_ir    <= cmdir_d;
      cmd_valid <= valid_d;
      busy      <= busy_d;
      overrun   <= ovr_d;
    end
  end

`ifdef DIRCC_DEBUG_SLAVE_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= par_d;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dircc_debug_scan_slave_mc.sv
// Directed self-checking bench for dircc_debug_scan_slave_mc (default 38-bit, 2-channel build).
module tb_dircc_debug_scan_slave_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        vji_tck, vji_tdi, vji_cdr, vji_sdr, vji_udr, vji_uir;
  logic [1:0]  vji_ir_in;
  logic        vji_tdo;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [1:0]  cmd_ir;
  logic [36:0] cmd_data;
  logic [73:0] rd_data;
  logic        busy, overrun, parity_err;

  int n_cmp = 0;
  int n_err = 0;

  dircc_debug_scan_slave_mc dut (
    .clk(clk), .reset(reset),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_uir(vji_uir), .vji_ir_in(vji_ir_in), .vji_tdo(vji_tdo),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rd_data(rd_data), .busy(busy), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tck_pulse();
    vji_tck = 1'b1; cyc(4);
    vji_tck = 1'b0; cyc(4);
  endtask

  task automatic shift_dr(input logic [37:0] v, output logic [37:0] out);
    vji_sdr = 1'b1; cyc(3);
    for (int i = 0; i < 38; i++) begin
      vji_tdi = v[i];
      vji_tck = 1'b1; cyc(4);
      out[i] = vji_tdo;
      vji_tck = 1'b0; cyc(4);
    end
    vji_sdr = 1'b0; cyc(3);
  endtask

  task automatic capture_dr();
    vji_cdr = 1'b1; cyc(3);
    tck_pulse();
    vji_cdr = 1'b0; cyc(3);
  endtask

  task automatic set_ir(input logic [1:0] v);
    vji_ir_in = v;
    vji_uir = 1'b1; cyc(4);
    vji_uir = 1'b0; cyc(4);
  endtask

  task automatic pulse_udr();
    vji_udr = 1'b1; cyc(4);
    vji_udr = 1'b0; cyc(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vji_tck = 0; vji_tdi = 0; vji_cdr = 0; vji_sdr = 0; vji_udr = 0; vji_uir = 0;
    vji_ir_in = 2'b00; cmd_ready = 2'b00; rd_data = '0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    n_cmp++; if (cmd_valid !== 2'b00) begin n_err++; $display("FAIL reset_cmd_valid: got %b expected 00", cmd_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (cmd_data !== 37'h0) begin n_err++; $display("FAIL reset_cmd_data: got %h expected 0", cmd_data); end
    n_cmp++; if ({cmd_ir, vji_tdo, overrun, parity_err} !== 5'b0) begin
      n_err++; $display("FAIL reset_misc: got ir=%b tdo=%b ovr=%b perr=%b expected all 0", cmd_ir, vji_tdo, overrun, parity_err);
    end
  endtask

  task automatic test_command();
    logic [37:0] dummy;
    int          n;
    set_ir(2'b01);
    shift_dr({1'b1, 37'h0_0000_0ABC}, dummy);
    vji_udr = 1'b1;
    n = 0;
    while (cmd_valid === 2'b00 && n < 8) begin cyc(1); n++; end
    n_cmp++; if (cmd_valid !== 2'b10) begin n_err++; $display("FAIL cmd_valid_first: got %b expected 10 (waited %0d cycles)", cmd_valid, n); end
    vji_udr = 1'b0;
    cyc(4);
    n_cmp++; if (cmd_data !== 37'hABC) begin n_err++; $display("FAIL cmd_data_first: got %h expected abc", cmd_data); end
    n_cmp++; if (cmd_ir !== 2'b01) begin n_err++; $display("FAIL cmd_ir_first: got %b expected 01", cmd_ir); end
    n_cmp++; if (busy !== 1'b1 || parity_err !== 1'b0) begin n_err++; $display("FAIL busy_first: got busy=%b perr=%b expected 1/0", busy, parity_err); end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_cmp++;
      if (cmd_valid !== 2'b10 || cmd_data !== 37'hABC || cmd_ir !== 2'b01) begin
        n_err++; $display("FAIL hold_stable[%0d]: got v=%b d=%h ir=%b expected 10/abc/01", i, cmd_valid, cmd_data, cmd_ir);
      end
    end
    cmd_ready = 2'b01;
    cyc(2);
    n_cmp++; if (cmd_valid !== 2'b10) begin n_err++; $display("FAIL other_ready_ignored: got %b expected 10", cmd_valid); end
    cmd_ready = 2'b10;
    cyc(1);
    cmd_ready = 2'b00;
    n_cmp++; if (cmd_valid !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL handshake_idle: got v=%b busy=%b expected 00/0", cmd_valid, busy); end
  endtask

  task automatic test_capture();
    logic [37:0] got;
    rd_data = {37'h1234_5678, 37'h0_0001_1111};
    capture_dr();
    shift_dr(38'h0, got);
    n_cmp++; if (got !== 38'h20_1234_5678) begin n_err++; $display("FAIL capture_tdo: got %h expected 2012345678", got); end
  endtask

  task automatic test_overrun();
    logic [37:0] dummy;
    shift_dr({1'b1, 37'h5}, dummy);
    pulse_udr();
    n_cmp++; if (cmd_valid !== 2'b10 || cmd_data !== 37'h5) begin n_err++; $display("FAIL ovr_first: got v=%b d=%h expected 10/5", cmd_valid, cmd_data); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear_before: got %b expected 0", overrun); end
    shift_dr({1'b0, 37'h7}, dummy);
    pulse_udr();
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    n_cmp++; if (cmd_valid !== 2'b10 || cmd_data !== 37'h5) begin n_err++; $display("FAIL ovr_keep: got v=%b d=%h expected 10/5", cmd_valid, cmd_data); end
    capture_dr();
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_read_clear: got %b expected 0", overrun); end
    cmd_ready = 2'b10;
    cyc(1);
    cmd_ready = 2'b00;
    n_cmp++; if (cmd_valid !== 2'b00) begin n_err++; $display("FAIL ovr_drain: got %b expected 00", cmd_valid); end
  endtask

  task automatic test_back_to_back();
    logic [37:0] dummy;
    shift_dr({1'b1, 37'h111}, dummy);
    pulse_udr();
    n_cmp++; if (cmd_valid !== 2'b10 || cmd_data !== 37'h111) begin n_err++; $display("FAIL b2b_first: got v=%b d=%h expected 10/111", cmd_valid, cmd_data); end
    shift_dr({1'b0, 37'h222}, dummy);
    vji_udr = 1'b1;
    cyc(2);
    cmd_ready = 2'b10;
    cyc(1);
    cmd_ready = 2'b00;
    n_cmp++; if (cmd_valid !== 2'b01 || cmd_data !== 37'h222 || busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_second: got v=%b d=%h busy=%b expected 01/222/1", cmd_valid, cmd_data, busy);
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    vji_udr = 1'b0;
    cyc(4);
    n_cmp++; if (cmd_valid !== 2'b01) begin n_err++; $display("FAIL b2b_hold: got %b expected 01", cmd_valid); end
    cmd_ready = 2'b01;
    cyc(1);
    cmd_ready = 2'b00;
    n_cmp++; if (cmd_valid !== 2'b00) begin n_err++; $display("FAIL b2b_drain: got %b expected 00", cmd_valid); end
  endtask

  task automatic test_reset_mid();
    logic [37:0] dummy;
    shift_dr({1'b1, 37'h333}, dummy);
    pulse_udr();
    n_cmp++; if (cmd_valid !== 2'b10) begin n_err++; $display("FAIL rst_mid_pend: got %b expected 10", cmd_valid); end
    reset = 1'b1;
    cyc(1);
    n_cmp++; if (cmd_valid !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got v=%b busy=%b expected 00/0", cmd_valid, busy); end
    n_cmp++; if (cmd_data !== 37'h0 || {cmd_ir, vji_tdo, overrun, parity_err} !== 5'b0) begin
      n_err++; $display("FAIL rst_mid_outputs: got d=%h ir=%b tdo=%b ovr=%b perr=%b expected all 0", cmd_data, cmd_ir, vji_tdo, overrun, parity_err);
    end
    reset = 1'b0;
    cyc(8);
    n_cmp++; if (cmd_valid !== 2'b00) begin n_err++; $display("FAIL rst_mid_spurious: got %b expected 00", cmd_valid); end
  endtask

`ifdef DIRCC_DEBUG_SLAVE_PARITY_EN
  task automatic test_parity();
    logic [37:0] dummy;
    shift_dr({1'b0, 37'h3}, dummy);
    pulse_udr();
    n_cmp++; if (cmd_valid !== 2'b00 || parity_err !== 1'b1) begin n_err++; $display("FAIL parity_even: got v=%b perr=%b expected 00/1", cmd_valid, parity_err); end
    shift_dr({1'b0, 37'h1}, dummy);
    pulse_udr();
    n_cmp++; if (cmd_valid !== 2'b01 || overrun !== 1'b0) begin n_err++; $display("FAIL parity_odd: got v=%b ovr=%b expected 01/0", cmd_valid, overrun); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DIRCC_DEBUG_SLAVE_PARITY_EN
    test_parity();
`else
    test_command();
    test_capture();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
